// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one operand pair in, WIDTH shift cycles
// through a single full-adder slice, parallel result out over valid/ready.
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cmsb_q, cmsb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_sum_q, out_sum_d;
    logic               out_cout_q, out_cout_d;
    logic               out_ovf_q, out_ovf_d;

    // The single full-adder slice operating on the current LSBs.
    logic slice_s, slice_c;
    assign slice_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign slice_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cmsb_q     <= 1'b0;
            cnt_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cmsb_q     <= cmsb_d;
            cnt_q      <= cnt_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cmsb_d     = cmsb_q;
        cnt_d      = cnt_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B and seed the carry.
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {slice_s, sum_q[WIDTH-1:1]};
                carry_d = slice_c;
                if (cnt_q == CNT_PENULT) begin
                    cmsb_d = slice_c;
                end
                if (cnt_q == CNT_LAST) begin
                    // Counter holds here so it never wraps for power-of-two widths.
                    out_sum_d  = {slice_s, sum_q[WIDTH-1:1]};
                    out_cout_d = slice_c;
                    out_ovf_d  = slice_c ^ cmsb_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_sum  = out_sum_q;
    assign out_cout = out_cout_q;
    assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq at WIDTH=4: vector table plus reset,
// backpressure and mid-operation reset sequences.
module tb_serial_add_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cycle     = 0;
    int last_acc  = 0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // One transaction; hold = cycles of out_ready=0 while DONE before release.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int hold);
        int t;
        int cyc;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk({nm, " in_ready timeout"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        last_acc = cycle;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub;
        chk({nm, " busy after accept"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'(W));
        chk({nm, " sum"},  32'(out_sum),  32'(es));
        chk({nm, " cout"}, 32'(out_cout), 32'(ec));
        chk({nm, " ovf"},  32'(out_ovf),  32'(eo));
        chk({nm, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, " hold valid"},    32'(out_valid), 32'd1);
            chk({nm, " hold in_ready"}, 32'(in_ready),  32'd0);
            chk({nm, " hold result"},   32'({out_sum, out_cout, out_ovf}), 32'({es, ec, eo}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " released valid"}, 32'(out_valid), 32'd0);
        chk({nm, " retained sum"},   32'(out_sum),   32'(es));
    endtask

    initial begin
        int prev_acc;
        int seen;

        vecs[0] = '{"add5+3",  4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1};
        vecs[1] = '{"add15+1", 4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
        vecs[2] = '{"sub6-2",  4'd6,  4'd2, 1'b1, 4'd4,  1'b1, 1'b0};
        vecs[3] = '{"sub2-6",  4'd2,  4'd6, 1'b1, 4'd12, 1'b0, 1'b0};
        vecs[4] = '{"add7+1",  4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
        vecs[5] = '{"sub8-1",  4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
        vecs[6] = '{"sub0-0",  4'd0,  4'd0, 1'b1, 4'd0,  1'b1, 1'b0};
        vecs[7] = '{"add9+9",  4'd9,  4'd9, 1'b0, 4'd2,  1'b1, 1'b1};
        vecs[8] = '{"sub3-5",  4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
        vecs[9] = '{"add12+3", 4'd12, 4'd3, 1'b0, 4'd15, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset out_sum",   32'(out_sum),   32'd0);

        // Back-to-back table: each accept should follow the previous by W+2 cycles.
        prev_acc = 0;
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub,
                  vecs[i].sum, vecs[i].cout, vecs[i].ovf, 0);
            if (i > 0) chk({vecs[i].name, " issue interval"}, 32'(last_acc - prev_acc), 32'(W + 2));
            prev_acc = last_acc;
        end

        // Backpressure: result must stay put for 10 cycles.
        do_op("backpressure 6-2", 4'd6, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0, 10);

        // Reset while cnt==2 inside SHIFT.
        in_a = 4'd15; in_b = 4'd15; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst busy",     32'(busy),     32'd0);
        chk("midrst out_sum",  32'(out_sum),  32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("midrst no result", 32'(seen), 32'd0);
        do_op("after reset 7+7", 4'd7, 4'd7, 1'b0, 4'd14, 1'b0, 1'b1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
